// File: rtl/div_ctrl_if.sv
// ---------------------------------------------------------------------------
// div_ctrl_if
// Bundles every signal between the execute stage, the divide controller and
// the shared iterative divider. clk/rst are not part of the bundle.
//
// Request side (execute stage -> controller):
//   req_valid, req_divsel[2:0], req_a[XLEN], req_b[XLEN], req_tag[TAG_W], flush
// Request side (controller -> execute stage):
//   req_ready, stall
// Response side (controller -> execute stage):
//   resp_valid, resp_data[XLEN], resp_tag[TAG_W]
// Divider side (controller -> divider):
//   div_divsel[2:0], div_a[XLEN], div_b[XLEN]
// Divider side (divider -> controller):
//   div_ready, div_res[XLEN]
//
// Modports:
//   slave  - the controller's view
//   master - the surrounding pipeline and divider's view
// ---------------------------------------------------------------------------
interface div_ctrl_if #(
  parameter int TAG_W = 5,
  parameter int XLEN  = 32
);

  logic             req_valid;
  logic [2:0]       req_divsel;
  logic [XLEN-1:0]  req_a;
  logic [XLEN-1:0]  req_b;
  logic [TAG_W-1:0] req_tag;
  logic             req_ready;
  logic             flush;
  logic             stall;
  logic             resp_valid;
  logic [XLEN-1:0]  resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic [2:0]       div_divsel;
  logic [XLEN-1:0]  div_a;
  logic [XLEN-1:0]  div_b;
  logic             div_ready;
  logic [XLEN-1:0]  div_res;

  modport slave (
    input  req_valid, req_divsel, req_a, req_b, req_tag, flush,
    input  div_ready, div_res,
    output req_ready, stall, resp_valid, resp_data, resp_tag,
    output div_divsel, div_a, div_b
  );

  modport master (
    output req_valid, req_divsel, req_a, req_b, req_tag, flush,
    output div_ready, div_res,
    input  req_ready, stall, resp_valid, resp_data, resp_tag,
    input  div_divsel, div_a, div_b
  );

endinterface

// File: rtl/div_ctrl.sv
// ---------------------------------------------------------------------------
// div_ctrl
// Sequences one M-extension divide request at a time between the execute
// stage and the shared iterative divider. Division by zero, signed overflow
// and a repeat of the last completed divider operation are answered on a
// fast path without starting the divider. While the divider runs, the
// pipeline is stalled; after a divider result the controller drains for two
// cycles with div_divsel=000 so the divider's ready window is cleared.
//
// Ports:
//   clk    - system clock
//   rst    - asynchronous active-high reset
//   io_bus - div_ctrl_if.slave; request/response handshake to the execute
//            stage, flush, stall, and the divider operand/select/result lines
//
// divsel encoding: 001 div, 010 divu, 011 rem, 100 remu; other codes are
// dropped without a response.
// ---------------------------------------------------------------------------
module div_ctrl #(
  parameter int TAG_W = 5,
  parameter int XLEN  = 32
) (
  input  logic         clk,
  input  logic         rst,
  div_ctrl_if.slave    io_bus
);

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_DIV  = 3'b001;
  localparam logic [2:0] SEL_DIVU = 3'b010;
  localparam logic [2:0] SEL_REM  = 3'b011;
  localparam logic [2:0] SEL_REMU = 3'b100;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RESP,
    DRAIN
  } state_t;

  state_t           r_state;
  state_t           w_nextState;

  // Request captured at accept
  logic [2:0]       r_divsel;
  logic [XLEN-1:0]  r_a;
  logic [XLEN-1:0]  r_b;
  logic [TAG_W-1:0] r_tag;
  logic [XLEN-1:0]  r_result;
  logic             r_fromSlow;
  logic             r_drainCnt;

  // Last completed divider operation
  logic             r_cacheValid;
  logic [2:0]       r_cacheDivsel;
  logic [XLEN-1:0]  r_cacheA;
  logic [XLEN-1:0]  r_cacheB;
  logic [XLEN-1:0]  r_cacheRes;

  logic             w_validSel;
  logic             w_accept;
  logic             w_isSigned;
  logic             w_isRemOp;
  logic             w_bZero;
  logic             w_overflow;
  logic             w_cacheHit;
  logic             w_fastPath;
  logic [XLEN-1:0]  w_fastRes;
  logic             w_divDone;

  // Request decode and fast-path evaluation. Everything here looks at the
  // live request so the fast-path decision and its result are ready in the
  // accept cycle. The accept is gated by rst so that every output, stall
  // included, reads 0 while reset is held.
  always_comb begin
    w_validSel = (io_bus.req_divsel >= SEL_DIV) && (io_bus.req_divsel <= SEL_REMU);
    w_accept   = !rst && io_bus.req_valid && (r_state == IDLE) && w_validSel && !io_bus.flush;
    w_isSigned = (io_bus.req_divsel == SEL_DIV) || (io_bus.req_divsel == SEL_REM);
    w_isRemOp  = (io_bus.req_divsel == SEL_REM) || (io_bus.req_divsel == SEL_REMU);
    w_bZero    = (io_bus.req_b == '0);
    w_overflow = w_isSigned && (io_bus.req_a == MOST_NEG) && (io_bus.req_b == ALL_ONES);
    w_cacheHit = r_cacheValid && (io_bus.req_divsel == r_cacheDivsel) &&
                 (io_bus.req_a == r_cacheA) && (io_bus.req_b == r_cacheB);
    w_fastPath = w_bZero || w_overflow || w_cacheHit;
    // Zero divisor and overflow take priority; in those cases a cached
    // entry would hold the same answer anyway since results are exact.
    w_fastRes  = r_cacheRes;
    if (w_bZero) begin
      w_fastRes = w_isRemOp ? io_bus.req_a : ALL_ONES;
    end else if (w_overflow) begin
      w_fastRes = w_isRemOp ? '0 : MOST_NEG;
    end
    w_divDone  = (r_state == RUN) && io_bus.div_ready && !io_bus.flush;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. A flush in RUN abandons the divide and goes straight
  // to DRAIN so the divider sees divsel=000 and forgets the operation.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nextState = w_fastPath ? RESP : RUN;
        end
      end
      RUN: begin
        if (io_bus.flush) begin
          w_nextState = DRAIN;
        end else if (io_bus.div_ready) begin
          w_nextState = RESP;
        end
      end
      RESP: begin
        w_nextState = r_fromSlow ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (r_drainCnt) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Output logic. The divider only sees the latched request while in RUN
  // and not flushing; everywhere else it sees divsel=000.
  always_comb begin
    io_bus.req_ready  = (r_state == IDLE) && !rst;
    io_bus.stall      = io_bus.req_valid && ((r_state != IDLE) || w_accept) && (r_state != RESP);
    io_bus.resp_valid = 1'b0;
    io_bus.resp_data  = '0;
    io_bus.resp_tag   = '0;
    io_bus.div_divsel = SEL_NONE;
    io_bus.div_a      = '0;
    io_bus.div_b      = '0;
    if ((r_state == RESP) && !io_bus.flush) begin
      io_bus.resp_valid = 1'b1;
      io_bus.resp_data  = r_result;
      io_bus.resp_tag   = r_tag;
    end
    if ((r_state == RUN) && !io_bus.flush) begin
      io_bus.div_divsel = r_divsel;
      io_bus.div_a      = r_a;
      io_bus.div_b      = r_b;
    end
  end

  // Two-cycle drain counter: 0 on the first DRAIN cycle, 1 on the second.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drainCnt <= 1'b0;
    end else begin
      r_drainCnt <= (r_state == DRAIN);
    end
  end

  // Request capture and result register. A fast-path result is loaded at
  // accept; a divider result is loaded on the first ready cycle in RUN,
  // which is also when the cache learns the operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_divsel   <= SEL_NONE;
      r_a        <= '0;
      r_b        <= '0;
      r_tag      <= '0;
      r_result   <= '0;
      r_fromSlow <= 1'b0;
    end else if (w_accept) begin
      r_divsel   <= io_bus.req_divsel;
      r_a        <= io_bus.req_a;
      r_b        <= io_bus.req_b;
      r_tag      <= io_bus.req_tag;
      r_fromSlow <= !w_fastPath;
      if (w_fastPath) begin
        r_result <= w_fastRes;
      end
    end else if (w_divDone) begin
      r_result <= io_bus.div_res;
    end
  end

  // Single-entry result cache; only reset invalidates it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cacheValid  <= 1'b0;
      r_cacheDivsel <= SEL_NONE;
      r_cacheA      <= '0;
      r_cacheB      <= '0;
      r_cacheRes    <= '0;
    end else if (w_divDone) begin
      r_cacheValid  <= 1'b1;
      r_cacheDivsel <= r_divsel;
      r_cacheA      <= r_a;
      r_cacheB      <= r_b;
      r_cacheRes    <= io_bus.div_res;
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_div_ctrl
// Self-checking bench for div_ctrl. A small behavioural divider answers the
// controller after a fixed latency and holds ready for two cycles. Expected
// results come from a constant vector table and are pushed to a scoreboard
// queue when each request is driven; a monitor pops and compares on every
// resp_valid.
// ---------------------------------------------------------------------------
module tb_div_ctrl;

  localparam int TAG_W = 5;
  localparam int XLEN  = 32;
  localparam int LAT   = 4;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] expData;
    bit          expFast;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
  } exp_t;

  logic clk;
  logic rst;

  int   checks;
  int   errors;
  int   divActiveCycles;
  exp_t sbQ[$];
  vec_t vecs[11];

  int   modelCnt;
  int   modelHold;

  div_ctrl_if #(.TAG_W(TAG_W), .XLEN(XLEN)) bus ();

  div_ctrl #(.TAG_W(TAG_W), .XLEN(XLEN)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus.slave)
  );

  // Free-running clock, 10 ns period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] divModel(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
    case (s)
      3'b001:  return $signed(a) / $signed(b);
      3'b010:  return a / b;
      3'b011:  return $signed(a) % $signed(b);
      3'b100:  return a % b;
      default: return 32'h0;
    endcase
  endfunction

  // Behavioural divider: after LAT cycles of a steady nonzero divsel it
  // raises ready with the result for two cycles, then drops it.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.div_ready <= 1'b0;
      bus.div_res   <= '0;
      modelCnt      <= 0;
      modelHold     <= 0;
    end else if (modelHold != 0) begin
      modelHold <= modelHold - 1;
      modelCnt  <= 0;
      if (modelHold == 1) bus.div_ready <= 1'b0;
    end else if (bus.div_divsel != 3'b000) begin
      if (modelCnt == LAT - 1) begin
        bus.div_ready <= 1'b1;
        bus.div_res   <= divModel(bus.div_divsel, bus.div_a, bus.div_b);
        modelHold     <= 2;
      end else begin
        modelCnt <= modelCnt + 1;
      end
    end else begin
      modelCnt <= 0;
    end
  end

  // Count cycles in which the divider is being asked to work
  always @(negedge clk) begin
    if (bus.div_divsel != 3'b000) divActiveCycles++;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every response must match the oldest expectation
  always @(negedge clk) begin
    if (bus.resp_valid) begin
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedResp: actual data=%h tag=%h required no response", bus.resp_data, bus.resp_tag);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput("respData", bus.resp_data, e.data);
        checkOutput("respTag", 32'(bus.resp_tag), 32'(e.tag));
      end
    end
  end

  // Drives one request, holds it like a stalled pipeline until the response,
  // then checks fast/slow latency and the drain back to IDLE.
  task automatic applyStimulus(input vec_t v);
    int waitCnt;
    int lat;
    int startActive;
    bit gotResp;
    waitCnt = 0;
    while (!bus.req_ready && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!bus.req_ready) begin
      checkOutput("readyTimeout", 32'd0, 32'd1);
      return;
    end
    startActive    = divActiveCycles;
    bus.req_valid  = 1'b1;
    bus.req_divsel = v.sel;
    bus.req_a      = v.a;
    bus.req_b      = v.b;
    bus.req_tag    = v.tag;
    sbQ.push_back('{v.expData, v.tag});
    lat     = 0;
    gotResp = 1'b0;
    while (!gotResp && lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus.resp_valid) begin
        gotResp = 1'b1;
      end else begin
        checkOutput("runStall", 32'(bus.stall), 32'd1);
        checkOutput("runDivsel", 32'(bus.div_divsel), 32'(v.sel));
      end
    end
    if (!gotResp) begin
      checkOutput("respTimeout", 32'd0, 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    checkOutput("respStall", 32'(bus.stall), 32'd0);
    bus.req_valid = 1'b0;
    checkOutput("fastPath", 32'(lat == 1), 32'(v.expFast));
    if (v.expFast) begin
      checkOutput("noDivStart", 32'(divActiveCycles - startActive), 32'd0);
      @(negedge clk);
      checkOutput("fastReady", 32'(bus.req_ready), 32'd1);
    end else begin
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        checkOutput("drainReady", 32'(bus.req_ready), 32'd0);
        checkOutput("drainDivsel", 32'(bus.div_divsel), 32'd0);
      end
      @(negedge clk);
      checkOutput("idleReady", 32'(bus.req_ready), 32'd1);
    end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    divActiveCycles = 0;
    rst             = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_divsel  = 3'b000;
    bus.req_a       = '0;
    bus.req_b       = '0;
    bus.req_tag     = '0;
    bus.flush       = 1'b0;

    //            sel     a             b             tag    expData       fast
    vecs[0]  = '{3'b010, 32'd100,      32'd7,        5'd3,  32'd14,       1'b0};
    vecs[1]  = '{3'b011, 32'hFFFFFFF9, 32'd2,        5'd4,  32'hFFFFFFFF, 1'b0};
    vecs[2]  = '{3'b011, 32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFF, 1'b1};
    vecs[3]  = '{3'b001, 32'd5,        32'd0,        5'd6,  32'hFFFFFFFF, 1'b1};
    vecs[4]  = '{3'b100, 32'd5,        32'd0,        5'd7,  32'd5,        1'b1};
    vecs[5]  = '{3'b001, 32'h80000000, 32'hFFFFFFFF, 5'd8,  32'h80000000, 1'b1};
    vecs[6]  = '{3'b011, 32'h80000000, 32'hFFFFFFFF, 5'd9,  32'h00000000, 1'b1};
    vecs[7]  = '{3'b001, 32'hFFFFFF9C, 32'd7,        5'd10, 32'hFFFFFFF2, 1'b0};
    vecs[8]  = '{3'b100, 32'd100,      32'd7,        5'd11, 32'd2,        1'b0};
    vecs[9]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h00000000, 1'b0};
    vecs[10] = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h00000000, 1'b1};

    // Outputs while reset is held
    repeat (2) @(negedge clk);
    checkOutput("rstReady", 32'(bus.req_ready), 32'd0);
    checkOutput("rstStall", 32'(bus.stall), 32'd0);
    checkOutput("rstRespValid", 32'(bus.resp_valid), 32'd0);
    checkOutput("rstRespData", bus.resp_data, 32'd0);
    checkOutput("rstDivsel", 32'(bus.div_divsel), 32'd0);
    checkOutput("rstDivA", bus.div_a, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("postRstReady", 32'(bus.req_ready), 32'd1);

    // Invalid divsel is dropped: no stall, no response, divider idle
    bus.req_valid  = 1'b1;
    bus.req_divsel = 3'b101;
    bus.req_a      = 32'd9;
    bus.req_b      = 32'd3;
    #1;
    checkOutput("badSelStall", 32'(bus.stall), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("badSelReady", 32'(bus.req_ready), 32'd1);
    checkOutput("badSelNoDiv", 32'(divActiveCycles), 32'd0);
    bus.req_valid = 1'b0;

    // Flush in IDLE blocks the accept
    bus.req_valid  = 1'b1;
    bus.req_divsel = 3'b001;
    bus.req_a      = 32'd5;
    bus.req_b      = 32'd0;
    bus.flush      = 1'b1;
    #1;
    checkOutput("idleFlushStall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    checkOutput("idleFlushReady", 32'(bus.req_ready), 32'd1);
    checkOutput("idleFlushNoResp", 32'(bus.resp_valid), 32'd0);
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    @(negedge clk);

    // Table-driven transactions
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
    end

    // Flush in the middle of a divide
    bus.req_valid  = 1'b1;
    bus.req_divsel = 3'b010;
    bus.req_a      = 32'd1000;
    bus.req_b      = 32'd3;
    bus.req_tag    = 5'd20;
    @(negedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    #1;
    checkOutput("flushDivsel", 32'(bus.div_divsel), 32'd0);
    checkOutput("flushNoResp", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    checkOutput("flushDrain0Ready", 32'(bus.req_ready), 32'd0);
    checkOutput("flushDrain0Divsel", 32'(bus.div_divsel), 32'd0);
    @(negedge clk);
    checkOutput("flushDrain1Ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    checkOutput("flushIdleReady", 32'(bus.req_ready), 32'd1);
    // Reissue: the flushed op never reached the cache, so it is a miss
    applyStimulus('{3'b010, 32'd1000, 32'd3, 5'd20, 32'd333, 1'b0});

    // Reset in the middle of a divide
    bus.req_valid  = 1'b1;
    bus.req_divsel = 3'b100;
    bus.req_a      = 32'd1000;
    bus.req_b      = 32'd7;
    bus.req_tag    = 5'd21;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midRstReady", 32'(bus.req_ready), 32'd0);
    checkOutput("midRstStall", 32'(bus.stall), 32'd0);
    checkOutput("midRstRespValid", 32'(bus.resp_valid), 32'd0);
    checkOutput("midRstDivsel", 32'(bus.div_divsel), 32'd0);
    checkOutput("midRstDivA", bus.div_a, 32'd0);
    checkOutput("midRstDivB", bus.div_b, 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst           = 1'b0;
    @(negedge clk);
    // 1000/3 was cached before reset; reset cleared it, so this is slow
    applyStimulus('{3'b010, 32'd1000, 32'd3, 5'd22, 32'd333, 1'b0});

    repeat (3) @(negedge clk);
    checkOutput("sbEmpty", 32'(sbQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencing controller between the execute stage and the shared iterative Divider (divsel-encoded div/divu/rem/remu).
- Accepts one M-extension divide request at a time and stalls the pipeline while the divider runs.
- Drives the divider's operand and select lines and captures its result.
- Resolves RISC-V corner cases (divide-by-zero, signed overflow) and repeated identical operations in a fast path, without starting the divider.

Parameters:
- TAG_W, 5, width of destination-register tag carried with each request.
- XLEN, 32, operand and result width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  request present
- req_divsel  in  3  001 div, 010 divu, 011 rem, 100 remu; other codes ignored
- req_a  in  XLEN  dividend
- req_b  in  XLEN  divisor
- req_tag  in  TAG_W  destination tag
- req_ready  out  1  controller can accept (state IDLE)
- flush  in  1  kill in-flight request
- stall  out  1  pipeline hold
- resp_valid  out  1  one-cycle result pulse
- resp_data  out  XLEN  result
- resp_tag  out  TAG_W  tag of result
- div_divsel  out  3  to divider divsel
- div_a  out  XLEN  to divider a
- div_b  out  XLEN  to divider b
- div_ready  in  1  divider ready
- div_res  in  XLEN  divider result

Behaviour:
- Reset, asynchronous:
  - state=IDLE; all outputs 0; div_divsel=000.
  - Cache valid bit cleared; captured operands, tag and result registers cleared.
- Accept: req_valid && req_ready && req_divsel in {001..100}. Operands, divsel and tag are latched in that same cycle. Requests with invalid codes are dropped with no response.
- Fast path, decided combinationally at accept; the result is registered and resp_valid pulses the next cycle (state RESP). The divider is not started.
  - b==0: div/divu -> 0xFFFFFFFF; rem/remu -> a.
  - div/rem with a==0x80000000 and b==0xFFFFFFFF: div -> 0x80000000; rem -> 0.
  - Cache hit: cache valid and divsel, a and b all equal the last completed divider op -> cached result.
- Slow path: IDLE -> RUN.
  - In RUN, div_divsel, div_a and div_b are driven from the latched values and held stable.
  - On the first cycle div_ready==1: capture div_res, update the cache (divsel, a, b, result, valid=1), then go to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, with resp_data and resp_tag from the latched values.
  - From the fast path, next state is IDLE. From the slow path, next state is DRAIN.
- DRAIN:
  - div_divsel=000 for 2 cycles (counter), which covers the divider's 2-cycle ready window and clears it.
  - Then IDLE. The divider must never see a nonzero divsel during DRAIN.
- stall = req_valid && (state!=IDLE || accepting this cycle) && state!=RESP. Net effect:
  - stall=0 in the cycle resp_valid is high.
  - stall=0 in IDLE with no request.
- req_ready=1 only in IDLE. A new request may be accepted the cycle after DRAIN completes, or the cycle after a fast-path RESP.
- flush, any state:
  - Suppresses a pending or same-cycle resp_valid.
  - RUN -> DRAIN, with div_divsel forced to 000 immediately. The cache is not updated.
  - IDLE or RESP: the accept is blocked that cycle.
  - flush in DRAIN has no effect.
- div_ready while not in RUN is ignored.
- Cache validity: the cache is invalidated only by reset. Results are bit-exact with the divider, so no further invalidation is needed.
- Width rules:
  - Signed compares use two's complement XLEN.
  - All equality compares are full width.

Test Plan:
- divu a=100, b=7 -> stall high in RUN; div_divsel=010 held; resp_data=14, tag echoed; then 2 DRAIN cycles with div_divsel=000; req_ready back high.
- rem a=0xFFFFFFF9 (-7), b=2 -> resp_data=0xFFFFFFFF (-1); repeating the same request -> resp one cycle after accept, div_divsel stays 000 (cache hit).
- div a=5, b=0 -> resp_data=0xFFFFFFFF next cycle; remu a=5, b=0 -> resp_data=5; divider never started.
- div a=0x80000000, b=0xFFFFFFFF -> resp_data=0x80000000; rem with same operands -> 0; both on the fast path.
- flush asserted mid-RUN -> no resp_valid; div_divsel=000 that cycle; DRAIN then IDLE; the same request reissued afterwards is a cache miss and runs the full divide.
- rst asserted mid-RUN -> all outputs 0 immediately, div_divsel=000, cache cleared.
